d2x_hazard_ctrl: RTL

//  Hazard/sequencing controller for the decode->execute pipeline register. Keeps shadow

---
 rtl/d2x_hazard_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/d2x_hazard_ctrl.sv
// d2x_hazard_ctrl
//   Hazard and sequencing controller that sits in decode beside the D->X pipeline register.
//   It keeps shadow copies of the X- and M-stage destination info and produces these controls:
//     - stall / bubble / flush / memory-hold
//     - the x2x / m2x forwarding selects that the D->X register captures
//
//   Ports
//     clk, rst                 clock (rising edge), asynchronous active-low reset
//     rdA*/rdB*                source register specifiers and read-valids of the decode instr
//     regWrtD, wrtRegD         decode instr writes register wrtRegD
//     readEnD                  decode instr is a load
//     brchTakenX               taken branch/jump resolved in X this cycle
//     memBusy                  data memory not done; whole pipe freezes
//     stallF, stallD           hold PC / F->D register
//     bubbleD                  NOP the control fields entering D->X
//     flushF                   squash the instr in F->D
//     holdX                    freeze D->X and everything downstream
//     x2x*/m2x*CntrlD          forwarding selects for ALU operands A/B
//
//   Optional build macro HAZ_PERF_CNT_EN adds two saturating 16-bit counters:
//     - stallCnt: load-use stall cycles
//     - flushCnt: branch flushes
module d2x_hazard_ctrl #(
   parameter int unsigned REG_BITS = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [REG_BITS-1:0] rdARegD,
   input  logic                rdAValidD,
   input  logic [REG_BITS-1:0] rdBRegD,
   input  logic                rdBValidD,
   input  logic                regWrtD,
   input  logic [REG_BITS-1:0] wrtRegD,
   input  logic                readEnD,
   input  logic                brchTakenX,
   input  logic                memBusy,
   output logic                stallF,
   output logic                stallD,
   output logic                bubbleD,
   output logic                flushF,
   output logic                holdX,
   output logic                x2xACntrlD,
   output logic                x2xBCntrlD,
   output logic                m2xACntrlD,
   output logic                m2xBCntrlD
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [15:0]         stallCnt,
   output logic [15:0]         flushCnt
`endif
);

   typedef enum logic [1:0] {StRun, StLdStall, StMemWait} state_e;

   state_e              state_q, state_d;
   logic                x_reg_wrt_q, x_reg_wrt_d;
   logic [REG_BITS-1:0] x_wrt_reg_q, x_wrt_reg_d;
   logic                x_read_en_q, x_read_en_d;
   logic                m_reg_wrt_q, m_reg_wrt_d;
   logic [REG_BITS-1:0] m_wrt_reg_q, m_wrt_reg_d;

   logic hold, brch, lu_hit, ld_use, kill, fwd_ok;
   logic x_match_a, x_match_b, m_match_a, m_match_b;
   logic x2x_a_raw, x2x_b_raw;

   // Hazard decode and output generation
   always_comb begin
      // Gating with rst keeps every output low while reset is held, even with memBusy high.
      hold   = rst & memBusy;
      brch   = rst & brchTakenX & ~memBusy;

      x_match_a = rdAValidD & x_reg_wrt_q & (x_wrt_reg_q == rdARegD);
      x_match_b = rdBValidD & x_reg_wrt_q & (x_wrt_reg_q == rdBRegD);
      m_match_a = rdAValidD & m_reg_wrt_q & (m_wrt_reg_q == rdARegD);
      m_match_b = rdBValidD & m_reg_wrt_q & (m_wrt_reg_q == rdBRegD);

      lu_hit = x_read_en_q & (x_match_a | x_match_b);
      // Branch and memory stall both outrank load-use.
      // LDSTALL never re-stalls: its bubble already cleared X.
      ld_use = lu_hit & ~memBusy & ~brchTakenX & (state_q != StLdStall);
      kill   = brch | ld_use;
      fwd_ok = ~(kill | hold);

      x2x_a_raw = x_match_a & ~x_read_en_q;
      x2x_b_raw = x_match_b & ~x_read_en_q;

      holdX      = hold;
      stallF     = hold | ld_use;
      stallD     = hold | ld_use;
      bubbleD    = kill;
      flushF     = brch;
      // The youngest producer wins: an X match suppresses the M select.
      x2xACntrlD = fwd_ok & x2x_a_raw;
      x2xBCntrlD = fwd_ok & x2x_b_raw;
      m2xACntrlD = fwd_ok & m_match_a & ~x2x_a_raw;
      m2xBCntrlD = fwd_ok & m_match_b & ~x2x_b_raw;
   end

   // Shadow pipeline and state next-state
   always_comb begin
      x_reg_wrt_d = x_reg_wrt_q;
      x_wrt_reg_d = x_wrt_reg_q;
      x_read_en_d = x_read_en_q;
      m_reg_wrt_d = m_reg_wrt_q;
      m_wrt_reg_d = m_wrt_reg_q;
      state_d     = state_q;

      if (!hold) begin
         x_reg_wrt_d = regWrtD & ~kill;
         x_wrt_reg_d = wrtRegD;
         x_read_en_d = readEnD & ~kill;
         m_reg_wrt_d = x_reg_wrt_q;
         m_wrt_reg_d = x_wrt_reg_q;
      end

      if (hold) begin
         state_d = StMemWait;
      end else begin
         unique case (state_q)
            StRun:     state_d = ld_use ? StLdStall : StRun;
            StLdStall: state_d = StRun;
            StMemWait: state_d = ld_use ? StLdStall : StRun;
            default:   state_d = StRun;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StRun;
         x_reg_wrt_q <= 1'b0;
         x_wrt_reg_q <= '0;
         x_read_en_q <= 1'b0;
         m_reg_wrt_q <= 1'b0;
         m_wrt_reg_q <= '0;
      end else begin
         state_q     <= state_d;
         x_reg_wrt_q <= x_reg_wrt_d;
         x_wrt_reg_q <= x_wrt_reg_d;
         x_read_en_q <= x_read_en_d;
         m_reg_wrt_q <= m_reg_wrt_d;
         m_wrt_reg_q <= m_wrt_reg_d;
      end
   end

`ifdef HAZ_PERF_CNT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [15:0] flush_cnt_q, flush_cnt_d;

   // ld_use and brch are already low while holdX is high, so frozen cycles never count.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (ld_use && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
      if (brch && (flush_cnt_q != 16'hFFFF)) begin
         flush_cnt_d = flush_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stallCnt = stall_cnt_q;
   assign flushCnt = flush_cnt_q;
`endif

endmodule
